// File: rtl/md_pkg.sv
// Shared op codes, latency defaults and op classification for the MD scheduler.
// MD_MADD_EN enables the multiply-accumulate op family (codes 7..10).
package md_pkg;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  typedef enum logic {IDLE, RUN} mdState_t;
  typedef enum logic [1:0] {ACC_NONE, ACC_ADD, ACC_SUB} accMode_t;

  function automatic logic isMaddClass(input logic [3:0] op);
`ifdef MD_MADD_EN
    return (op == OP_MADD) || (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic isMultClass(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || isMaddClass(op);
  endfunction

  function automatic logic isDivClass(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic isMdClass(input logic [3:0] op);
    return isMultClass(op) || isDivClass(op);
  endfunction

  function automatic accMode_t accModeOf(input logic [3:0] op);
    if (!isMaddClass(op))                       return ACC_NONE;
    else if (op == OP_MADD || op == OP_MADDU)   return ACC_ADD;
    else                                        return ACC_SUB;
  endfunction

endpackage

// File: rtl/md_sched_if.sv
// Pipeline-facing handshake of the MD scheduler: issue, operands, HI/LO read and stall.
interface md_sched_if;
  logic        start;
  logic [3:0]  md_op;
  logic [31:0] a;
  logic [31:0] b;
  logic        rd_hi;
  logic        md_use_d;
  logic [31:0] out;
  logic        busy;
  logic        stall_d;

  modport master (output start, md_op, a, b, rd_hi, md_use_d,
                  input  out, busy, stall_d);
  modport slave  (input  start, md_op, a, b, rd_hi, md_use_d,
                  output out, busy, stall_d);
endinterface

// File: rtl/md_arith.sv
// Combinational MD datapath: 64-bit {hi,lo} result of a mult/div op, with the
// divide-by-zero and signed-overflow results forced explicitly.
module md_arith
  import md_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] res
);

  logic [63:0] sA, sB, uA, uB;
  logic [31:0] sQ, sR, uQ, uR;

  always_comb begin
    sA = {{32{a[31]}}, a};
    sB = {{32{b[31]}}, b};
    uA = {32'd0, a};
    uB = {32'd0, b};
    sQ = '0;
    sR = '0;
    uQ = '0;
    uR = '0;
    res = '0;
    unique case (op)
      OP_MULT, OP_MADD, OP_MSUB:    res = sA * sB;
      OP_MULTU, OP_MADDU, OP_MSUBU: res = uA * uB;
      OP_DIV: begin
        if (b == '0)
          res = {a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == '1)
          res = {32'd0, 32'h8000_0000};
        else begin
          sQ = $signed(a) / $signed(b);
          sR = $signed(a) % $signed(b);
          res = {sR, sQ};
        end
      end
      OP_DIVU: begin
        if (b == '0)
          res = {a, 32'hFFFF_FFFF};
        else begin
          uQ = a / b;
          uR = a % b;
          res = {uR, uQ};
        end
      end
      default: res = '0;
    endcase
  end

endmodule

// File: rtl/md_sched.sv
// E-stage multiply/divide scheduler: busy counter, pending result, HI/LO and D-stall.
// MD_MADD_EN adds madd/maddu/msub/msubu accumulating into {HI,LO} at commit.
module md_sched
  import md_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input logic       clk,
  input logic       reset,
  md_sched_if.slave md
);

  mdState_t    state, stateNext;
  logic [3:0]  cnt, cntNext;
  logic [63:0] pend, pendNext;
  accMode_t    acc, accNext;
  logic [31:0] hi, hiNext, lo, loNext;
  logic [63:0] arithRes;

  md_arith uArith (
    .op  (md.md_op),
    .a   (md.a),
    .b   (md.b),
    .res (arithRes)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      pend  <= '0;
      acc   <= ACC_NONE;
      hi    <= '0;
      lo    <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
      pend  <= pendNext;
      acc   <= accNext;
      hi    <= hiNext;
      lo    <= loNext;
    end
  end

  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    pendNext  = pend;
    accNext   = acc;
    hiNext    = hi;
    loNext    = lo;
    unique case (state)
      IDLE: begin
        if (md.start) begin
          if (isMdClass(md.md_op)) begin
            stateNext = RUN;
            pendNext  = arithRes;
            accNext   = accModeOf(md.md_op);
            cntNext   = isDivClass(md.md_op) ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
          end else if (md.md_op == OP_MTHI) begin
            hiNext = md.a;
          end else if (md.md_op == OP_MTLO) begin
            loNext = md.a;
          end
        end
      end
      RUN: begin
        // Accumulation uses {HI,LO} at commit time, not at issue.
        cntNext = cnt - 4'd1;
        if (cnt == 4'd1) begin
          stateNext = IDLE;
          unique case (acc)
            ACC_ADD: {hiNext, loNext} = {hi, lo} + pend;
            ACC_SUB: {hiNext, loNext} = {hi, lo} - pend;
            default: {hiNext, loNext} = pend;
          endcase
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    md.busy    = (state == RUN);
    md.out     = md.rd_hi ? hi : lo;
    md.stall_d = md.md_use_d & ((state == RUN) | (md.start & isMdClass(md.md_op)));
  end

endmodule
